// File: rtl/spi_frame_writer_if.sv
// Byte-stream side of the SPI slave plus the pixel BRAM write port, bundled
// for the frame writer. The master modport is the writer, slave is its environment.
interface spi_frame_writer_if #(
  parameter int ADDRESS_WIDTH = 13
) ();
  logic [7:0]               spi_dout;
  logic                     spi_done;
  logic                     spi_selected;
  logic [7:0]               spi_din;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [7:0]               mem_wdata;
  logic                     frame_latch;

  modport master (
    input  spi_dout, spi_done, spi_selected,
    output spi_din, mem_we, mem_waddr, mem_wdata, frame_latch
  );

  modport slave (
    output spi_dout, spi_done, spi_selected,
    input  spi_din, mem_we, mem_waddr, mem_wdata, frame_latch
  );
endinterface

// File: rtl/spi_frame_writer.sv
// Command packet decoder: streams WRITE payloads into BRAM with range checks,
// pulses frame_latch on LATCH and reports sticky error flags back over SPI.
module spi_frame_writer #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int MEMORY_SIZE   = 7200
) (
  input  logic clk,
  input  logic resetn,
  spi_frame_writer_if.master bus
);
  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] PTR_LIMIT  = PW'(MEMORY_SIZE);
  localparam logic [15:0]   ADDR_LIMIT = 16'(MEMORY_SIZE);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, DATA, IGNORE
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               addr_hi_q, addr_hi_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     err_cmd_q, err_cmd_d;
  logic                     err_range_q, err_range_d;
  logic [7:0]               spi_din_q, spi_din_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]               mem_wdata_q, mem_wdata_d;
  logic                     frame_latch_q, frame_latch_d;
  logic [15:0]              addr16;

  assign addr16 = {addr_hi_q, bus.spi_dout};

  always_comb begin
    state_d       = state_q;
    addr_hi_d     = addr_hi_q;
    ptr_d         = ptr_q;
    err_cmd_d     = err_cmd_q;
    err_range_d   = err_range_q;
    mem_we_d      = 1'b0;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    frame_latch_d = 1'b0;
    // Status mirrors the flags one cycle late, as the slave preloads it.
    spi_din_d     = {6'b0, err_cmd_q, err_range_q};

    // Deselect wins over a coincident strobe: the byte is dropped.
    if (!bus.spi_selected) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (bus.spi_done) begin
            case (bus.spi_dout)
              8'h00: state_d = IGNORE;
              8'h01: state_d = ADDR_HI;
              8'h02: begin
                frame_latch_d = 1'b1;
                state_d       = IGNORE;
              end
              8'h03: begin
                err_cmd_d   = 1'b0;
                err_range_d = 1'b0;
                state_d     = IGNORE;
              end
              default: begin
                err_cmd_d = 1'b1;
                state_d   = IGNORE;
              end
            endcase
          end
        end
        ADDR_HI: begin
          if (bus.spi_done) begin
            addr_hi_d = bus.spi_dout;
            state_d   = ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (bus.spi_done) begin
            if (addr16 >= ADDR_LIMIT) begin
              err_range_d = 1'b1;
              state_d     = IGNORE;
            end else begin
              ptr_d   = PW'(addr16);
              state_d = DATA;
            end
          end
        end
        DATA: begin
          // ptr stops at the limit, so overflow bytes keep flagging instead of wrapping.
          if (bus.spi_done) begin
            if (ptr_q < PTR_LIMIT) begin
              mem_we_d    = 1'b1;
              mem_waddr_d = ptr_q[ADDRESS_WIDTH-1:0];
              mem_wdata_d = bus.spi_dout;
              ptr_d       = ptr_q + 1'b1;
            end else begin
              err_range_d = 1'b1;
            end
          end
        end
        IGNORE:  state_d = IGNORE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_hi_q     <= '0;
      ptr_q         <= '0;
      err_cmd_q     <= 1'b0;
      err_range_q   <= 1'b0;
      spi_din_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      frame_latch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_hi_q     <= addr_hi_d;
      ptr_q         <= ptr_d;
      err_cmd_q     <= err_cmd_d;
      err_range_q   <= err_range_d;
      spi_din_q     <= spi_din_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      frame_latch_q <= frame_latch_d;
    end
  end

  assign bus.spi_din     = spi_din_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_waddr   = mem_waddr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.frame_latch = frame_latch_q;
endmodule

// File: tb/tb_spi_frame_writer.sv
// Directed bench for spi_frame_writer: a packet table plus hand-written
// sequences for back-to-back strobes, select/done collision and async reset.
module tb_spi_frame_writer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  spi_frame_writer_if #(.ADDRESS_WIDTH(13)) bus ();

  spi_frame_writer #(.ADDRESS_WIDTH(13), .MEMORY_SIZE(7200)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b [6];
    int         exp_writes;
    int         exp_addr0;
    logic [7:0] exp_status;
    int         exp_latch;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int latch_cnt = 0;
  int wr_addr_q[$];
  int wr_data_q[$];

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(int'(bus.mem_waddr));
      wr_data_q.push_back(int'(bus.mem_wdata));
    end
    if (bus.frame_latch) latch_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.spi_dout = b;
    bus.spi_done = 1'b1;
    @(negedge clk);
    bus.spi_done = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat0;
    wr_addr_q.delete();
    wr_data_q.delete();
    lat0 = latch_cnt;
    @(negedge clk);
    bus.spi_selected = 1'b1;
    @(negedge clk);
    for (int i = 0; i < v.n; i++) send_byte(v.b[i]);
    bus.spi_selected = 1'b0;
    repeat (3) @(negedge clk);
    chk({v.name, " writes"}, wr_addr_q.size(), v.exp_writes);
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (i < v.exp_writes && 3 + i < 6) begin
        chk($sformatf("%s addr%0d", v.name, i), wr_addr_q[i], v.exp_addr0 + i);
        chk($sformatf("%s data%0d", v.name, i), wr_data_q[i], int'(v.b[3+i]));
      end
    end
    chk({v.name, " latch"}, latch_cnt - lat0, v.exp_latch);
    chk({v.name, " status"}, int'(bus.spi_din), int'(v.exp_status));
  endtask

  vec_t vecs [9];
  vec_t v;

  initial begin
    vecs[0] = '{"basic",     6, '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC}, 3, 16, 8'h00, 0};
    vecs[1] = '{"end_mem",   6, '{8'h01, 8'h1C, 8'h1E, 8'h11, 8'h22, 8'h33}, 2, 7198, 8'h01, 0};
    vecs[2] = '{"oob_addr",  3, '{8'h01, 8'h1C, 8'h20, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h01, 0};
    vecs[3] = '{"latch",     1, '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h01, 1};
    vecs[4] = '{"clear1",    1, '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h00, 0};
    vecs[5] = '{"bad_cmd",   1, '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h02, 0};
    vecs[6] = '{"clear2",    1, '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h00, 0};
    vecs[7] = '{"truncated", 2, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h00, 0};
    vecs[8] = '{"resync",    4, '{8'h01, 8'h00, 8'h05, 8'h99, 8'h00, 8'h00}, 1, 5, 8'h00, 0};

    bus.spi_dout = 8'h00;
    bus.spi_done = 1'b0;
    bus.spi_selected = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst spi_din", int'(bus.spi_din), 0);
    chk("rst mem_we", int'(bus.mem_we), 0);
    chk("rst mem_waddr", int'(bus.mem_waddr), 0);
    chk("rst mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst frame_latch", int'(bus.frame_latch), 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Four strobes on consecutive cycles starting at address 100.
    bus.spi_selected = 1'b1;
    @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h64);
    for (int i = 0; i < 4; i++) begin
      bus.spi_dout = 8'hA0 + 8'(i);
      bus.spi_done = 1'b1;
      @(negedge clk);
      chk($sformatf("b2b we%0d", i), int'(bus.mem_we), 1);
      chk($sformatf("b2b addr%0d", i), int'(bus.mem_waddr), 100 + i);
      chk($sformatf("b2b data%0d", i), int'(bus.mem_wdata), 'hA0 + i);
    end
    bus.spi_done = 1'b0;
    @(negedge clk);
    chk("b2b we_off", int'(bus.mem_we), 0);
    chk("b2b addr_hold", int'(bus.mem_waddr), 103);
    bus.spi_selected = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe coincident with deselect must be dropped.
    bus.spi_selected = 1'b1;
    @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h14);
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.spi_dout = 8'h55;
    bus.spi_done = 1'b1;
    bus.spi_selected = 1'b0;
    @(negedge clk);
    bus.spi_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("collide writes", wr_addr_q.size(), 0);

    // Async reset with a write pulse in flight and a flag set.
    v = '{"set_err", 1, '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 8'h02, 0};
    run_vec(v);
    bus.spi_selected = 1'b1;
    @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'hEE);
    chk("pre_rst we", int'(bus.mem_we), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst mem_we", int'(bus.mem_we), 0);
    chk("arst mem_waddr", int'(bus.mem_waddr), 0);
    chk("arst mem_wdata", int'(bus.mem_wdata), 0);
    chk("arst spi_din", int'(bus.spi_din), 0);
    chk("arst frame_latch", int'(bus.frame_latch), 0);
    bus.spi_selected = 1'b0;
    #1 resetn = 1'b1;
    @(negedge clk);
    v = '{"post_rst", 4, '{8'h01, 8'h00, 8'h40, 8'h77, 8'h00, 8'h00}, 1, 64, 8'h00, 0};
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_frame_writer.md
# spi_frame_writer

Packet decoder between the SPI slave's byte stream and the pixel BRAM write port. Parses command packets (NOP, WRITE, LATCH, CLEAR_STATUS), streams WRITE payload bytes into consecutive BRAM addresses with range checking, and emits a one-cycle `frame_latch` pulse for the strip drivers. It also returns a sticky status byte to the SPI master on every transfer.

## Interface
- `ADDRESS_WIDTH`, 13: BRAM write address width.
- `MEMORY_SIZE`, 7200: number of valid BRAM bytes (8 drivers × 900 channels); valid addresses are 0..MEMORY_SIZE-1.

- `clk`  in  1  system clock (50 MHz domain).
- `resetn`  in  1  asynchronous, active-low reset.
- `spi_dout`  in  8  byte received from the SPI slave; valid when `spi_done`=1.
- `spi_done`  in  1  one-cycle strobe: a byte has been received.
- `spi_selected`  in  1  level, high while chip-select is asserted.
- `spi_din`  out  8  status byte loaded into the slave for the next transfer.
- `mem_we`  out  1  BRAM write enable, one-cycle pulse.
- `mem_waddr`  out  ADDRESS_WIDTH  BRAM write address.
- `mem_wdata`  out  8  BRAM write data.
- `frame_latch`  out  1  one-cycle pulse: frame complete, drivers may refresh.

## Operation
- **States:** IDLE, CMD, ADDR_HI, ADDR_LO, DATA, IGNORE.
- **Deselect:** whenever `spi_selected`=0, the next state is IDLE from any state. `spi_done` is ignored while `spi_selected`=0.
- **IDLE:** `spi_selected`=1 moves to CMD.
- **CMD**, on `spi_done`:
  - 0x00 NOP: move to IGNORE.
  - 0x01 WRITE: move to ADDR_HI.
  - 0x02 LATCH: pulse `frame_latch`, move to IGNORE.
  - 0x03 CLEAR_STATUS: clear both error flags, move to IGNORE.
  - Any other value: set `err_cmd`, move to IGNORE.
- **ADDR_HI:** on `spi_done`, latch the high byte and move to ADDR_LO.
- **ADDR_LO:** on `spi_done`, form `addr16 = {hi, lo}`.
  - If `addr16 >= MEMORY_SIZE`: set `err_range`, move to IGNORE.
  - Otherwise: load `ptr = addr16` and move to DATA.
- **DATA:** on `spi_done`:
  - If `ptr < MEMORY_SIZE`: write `spi_dout` to `ptr`, then increment `ptr`.
  - Otherwise: drop the byte and set `err_range`.
  - Remain in DATA until deselect.
- **IGNORE:** consume bytes with no effect until deselect.
- **Pointer width:** `ptr` is ADDRESS_WIDTH+1 bits so it can reach MEMORY_SIZE. It saturates at MEMORY_SIZE and never wraps.
- **Status:** `spi_din = {6'b0, err_cmd, err_range}`.
  - Both flags are sticky across packets.
  - They are cleared only by reset or CLEAR_STATUS.
  - `spi_din` updates the cycle after the flag changes.
- **Partial packets:** a packet cut short by deselect leaves already-written bytes in place; there is no rollback.

## Timing
- **Reset values:** `spi_din`=0x00, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0x00, `frame_latch`=0, state IDLE, both flags 0.
- **Write latency:** `mem_we`, `mem_waddr` and `mem_wdata` are registered. `mem_we` is high exactly in cycle N+1 for a DATA `spi_done` in cycle N. Address and data are held until the next write.
- **Latch latency:** `frame_latch` is high in cycle N+1 for a LATCH `spi_done` in cycle N, for exactly one cycle.
- **Back-to-back strobes:** `spi_done` in consecutive cycles gives `mem_we` high in consecutive cycles, each with the correct incremented address.
- **Select vs. done:** if `spi_selected` falls in the same cycle as `spi_done`, the byte is discarded and the state goes to IDLE.
- **Async reset:** `resetn` low clears all registers immediately, including a `mem_we` or `frame_latch` pulse in flight. Operation resumes on the first clock edge after `resetn` goes high.
- **Throughput:** one byte per cycle sustained; no backpressure.

## Test plan
- **Basic write:** select, send 0x01 0x00 0x10 0xAA 0xBB 0xCC, deselect → three `mem_we` pulses, at addr 0x010/0x011/0x012 with data 0xAA/0xBB/0xCC; each pulse 1 cycle after its `spi_done`.
- **Range and end-of-memory:**
  - Send 0x01 0x1C 0x1E (addr 7198) then 0x11 0x22 0x33 → writes at 7198 and 7199 only; third byte dropped; `spi_din` = 0x01.
  - A new packet 0x01 0x1C 0x20 (addr 7200) → no writes; `err_range` stays set.
- **Latch and status clear:**
  - Send 0x02 → `frame_latch` high for exactly 1 cycle; no `mem_we`.
  - Send 0x7F → `spi_din` = 0x02.
  - Send 0x03 → `spi_din` = 0x00.
- **Truncation and re-sync:**
  - Send 0x01 0x00, deselect mid-packet → no write.
  - Reselect and send 0x01 0x00 0x05 0x99 → single write, addr 5, data 0x99.
  - `spi_done` coincident with the falling `spi_selected` → byte discarded.
- **Back-to-back bytes:** `spi_done` on 4 consecutive cycles in DATA from addr 100 → `mem_we` high 4 consecutive cycles, addr 100..103.
- **Async reset mid-packet:** assert `resetn`=0 mid-DATA, off a clock edge → all outputs 0 immediately. After release, a fresh 0x01 packet writes correctly.
